// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 32-bit CPU control path:
//     - opcode values (IR[31:27])
//     - IR field bit positions for op / Ra / Rb / Rc
//     - control-step state encoding
//     - instruction class enum plus the opcode -> class decoder
//     - the control-strobe bundle driven by the output decode
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Widths and limits
    localparam int OP_W         = 5;
    localparam int REG_IDX_W    = 4;
    localparam int NUM_REGS     = 16;
    localparam int WAIT_W       = 4;
    localparam int MEM_WAIT_MAX = 15;

    // IR field bit positions
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // Opcodes
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b10011;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b10100;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // Control steps. T3..T7 are shared by all instruction classes; the
    // class picks which strobes a step drives and where it goes next.
    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU,      // three-register ALU ops
        CLS_IMM,      // register/immediate ALU ops
        CLS_UNARY,    // neg / not
        CLS_MULDIV,   // mul / div, 64-bit result into HI:LO
        CLS_LOAD,
        CLS_STORE,
        CLS_MFHI,
        CLS_MFLO,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // One bit per datapath strobe, plus the register-select requests
    // (gra/grb/grc + r_in/r_out) that reg_select_encode turns into one-hot
    // vectors. alu_en passes the opcode through; alu_add forces ADD for
    // effective-address computation.
    typedef struct packed {
        logic pc_out;
        logic zhigh_out;
        logic zlow_out;
        logic mdr_out;
        logic hi_out;
        logic lo_out;
        logic c_out;
        logic ba_out;
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic hi_in;
        logic lo_in;
        logic inc_pc;
        logic read;
        logic write;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic alu_en;
        logic alu_add;
    } ctrl_t;

    function automatic op_class_t decode_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:     return CLS_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:            return CLS_IMM;
            OP_NEG, OP_NOT:                      return CLS_UNARY;
            OP_MUL, OP_DIV:                      return CLS_MULDIV;
            OP_LD:                               return CLS_LOAD;
            OP_ST:                               return CLS_STORE;
            OP_MFHI:                             return CLS_MFHI;
            OP_MFLO:                             return CLS_MFLO;
            OP_NOP:                              return CLS_NOP;
            OP_HALT:                             return CLS_HALT;
            default:                             return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_encode.sv
// ---------------------------------------------------------------------------
// reg_select_encode
//   Turns the register-select requests of one control step into the
//   datapath's one-hot GPR enables.
//   Ports:
//     ra, rb, rc      in  4   register fields from IR
//     gra, grb, grc   in  1   which field addresses the register this step
//     r_in            in  1   load the selected register
//     r_out           in  1   drive the selected register onto the bus
//     ba_out          in  1   base-address drive (also enables the register)
//     rin_vec         out 16  one-hot load enable
//     rout_vec        out 16  one-hot drive enable
//   Only one field is used per step, so a single decoder serves both
//   vectors and each vector has at most one bit set.
// ---------------------------------------------------------------------------
module reg_select_encode
    import cpu_pkg::*;
(
    input  logic [REG_IDX_W-1:0] ra,
    input  logic [REG_IDX_W-1:0] rb,
    input  logic [REG_IDX_W-1:0] rc,
    input  logic                 gra,
    input  logic                 grb,
    input  logic                 grc,
    input  logic                 r_in,
    input  logic                 r_out,
    input  logic                 ba_out,
    output logic [NUM_REGS-1:0]  rin_vec,
    output logic [NUM_REGS-1:0]  rout_vec
);

    logic [REG_IDX_W-1:0] sel;
    logic                 any_sel;
    logic [NUM_REGS-1:0]  one_hot;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sel     = '0;
        one_hot = '0;
        if (gra) begin
            sel = ra;
        end else if (grb) begin
            sel = rb;
        end else if (grc) begin
            sel = rc;
        end
        one_hot[sel] = 1'b1;
    end

    assign any_sel  = gra | grb | grc;
    assign rin_vec  = (any_sel && r_in)             ? one_hot : '0;
    assign rout_vec = (any_sel && (r_out || ba_out)) ? one_hot : '0;

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Moore sequencer for the 32-bit datapath: instruction fetch (T0-T2) and
//   per-opcode execute steps (T3-T7). One control step per Clock cycle;
//   registers enabled in a step load on the edge that ends it.
//   Parameters:
//     MEM_WAIT  extra cycles a memory Read/Write step is held (0..15)
//   Ports:
//     Clock, Resetn           clock (rising edge), async active-low reset
//     Run                     leave IDLE and start fetching
//     Stop                    at an instruction boundary, return to IDLE
//     IR                      instruction register contents
//     PCout..BAout            bus-source selects
//     PCin..LOin              register load enables
//     IncPC, Read, Write      PC increment, memory strobes
//     Rin, Rout               one-hot GPR load / drive enables
//     alu_op                  ALU opcode (IR[31:27] in ALU steps, else 0)
//     Busy, Halted, Illegal   status; Illegal is sticky until reset
//   Strobes depend only on the state register and on IR fields. The
//   instruction class comes from IR[31:27]; IR is loaded at the end of T2,
//   so the class is only consulted from T3 on.
// ---------------------------------------------------------------------------
module control_unit
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Run,
    input  logic                Stop,
    input  logic [31:0]         IR,
    output logic                PCout,
    output logic                Zhighout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                HIout,
    output logic                LOout,
    output logic                Cout,
    output logic                BAout,
    output logic                PCin,
    output logic                MARin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic                Write,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [OP_W-1:0]     alu_op,
    output logic                Busy,
    output logic                Halted,
    output logic                Illegal
);

    // Out-of-range MEM_WAIT saturates to the counter's reach.
    localparam logic [WAIT_W-1:0] WAIT_LOAD = (MEM_WAIT > MEM_WAIT_MAX) ?
                                              WAIT_W'(MEM_WAIT_MAX) :
                                              WAIT_W'(MEM_WAIT);

    state_t            state;
    state_t            state_next;
    state_t            boundary_next;
    op_class_t         op_class;
    logic [OP_W-1:0]   op;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;
    logic              mem_now;
    logic              mem_next;
    logic              illegal_q;
    ctrl_t             ctrl;

    // Immediate and low IR bits belong to the datapath, not to sequencing.
    logic              unused_ir;
    assign unused_ir = ^IR[RC_LSB-1:0];

    assign op        = IR[OP_MSB:OP_LSB];
    assign op_class  = decode_op(op);
    assign wait_done = (wait_cnt == '0);

    // Memory steps are the ones held for 1+MEM_WAIT cycles.
    function automatic logic is_mem_step(input state_t st, input op_class_t cls);
        return (st == S_T1) ||
               (st == S_T6 && cls == CLS_LOAD) ||
               (st == S_T7 && cls == CLS_STORE);
    endfunction

    assign mem_now  = is_mem_step(state, op_class);
    assign mem_next = is_mem_step(state_next, op_class);

    // -----------------------------------------------------------------------
    // State register, wait counter, sticky Illegal flag
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments and an async
    // active-low reset, so reset takes effect without waiting for Clock.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wait_cnt <= '0;
        end else if (mem_next && (state_next != state)) begin
            wait_cnt <= WAIT_LOAD;
        end else if (mem_now && !wait_done) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            illegal_q <= 1'b0;
        end else if (state == S_T3 && op_class == CLS_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // Last execute step of every instruction leads here.
    assign boundary_next = Stop ? S_IDLE : S_T0;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (Run) state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   if (wait_done) state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3: begin
                case (op_class)
                    CLS_ALU, CLS_IMM, CLS_UNARY,
                    CLS_MULDIV, CLS_LOAD, CLS_STORE: state_next = S_T4;
                    CLS_HALT, CLS_ILLEGAL:           state_next = S_HALT;
                    default:                         state_next = boundary_next;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CLS_ALU, CLS_IMM, CLS_MULDIV,
                    CLS_LOAD, CLS_STORE:             state_next = S_T5;
                    default:                         state_next = boundary_next;
                endcase
            end
            S_T5: begin
                case (op_class)
                    CLS_MULDIV, CLS_LOAD, CLS_STORE: state_next = S_T6;
                    default:                         state_next = boundary_next;
                endcase
            end
            S_T6: begin
                case (op_class)
                    CLS_LOAD:  if (wait_done) state_next = S_T7;
                    CLS_STORE: state_next = S_T7;
                    default:   state_next = boundary_next;
                endcase
            end
            S_T7: begin
                if (op_class != CLS_STORE || wait_done) begin
                    state_next = boundary_next;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        ctrl = '0;
        case (state)
            S_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.pc_in  = 1'b1;
            end
            S_T1: begin
                ctrl.read   = 1'b1;
                ctrl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    CLS_ALU, CLS_IMM: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1;
                        ctrl.alu_en = 1'b1; ctrl.z_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CLS_MFHI: begin
                        ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CLS_MFLO: begin
                        ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CLS_ALU: begin
                        ctrl.grc = 1'b1; ctrl.r_out = 1'b1;
                        ctrl.alu_en = 1'b1; ctrl.z_in = 1'b1;
                    end
                    CLS_IMM: begin
                        ctrl.c_out = 1'b1; ctrl.alu_en = 1'b1; ctrl.z_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1;
                        ctrl.alu_en = 1'b1; ctrl.z_in = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        ctrl.c_out = 1'b1; ctrl.alu_add = 1'b1; ctrl.z_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    CLS_ALU, CLS_IMM: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_class)
                    CLS_MULDIV: begin
                        ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
                    end
                    CLS_LOAD: begin
                        ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    CLS_STORE: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_class)
                    CLS_LOAD: begin
                        ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CLS_STORE: ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    reg_select_encode u_reg_select_encode (
        .ra       (IR[RA_MSB:RA_LSB]),
        .rb       (IR[RB_MSB:RB_LSB]),
        .rc       (IR[RC_MSB:RC_LSB]),
        .gra      (ctrl.gra),
        .grb      (ctrl.grb),
        .grc      (ctrl.grc),
        .r_in     (ctrl.r_in),
        .r_out    (ctrl.r_out),
        .ba_out   (ctrl.ba_out),
        .rin_vec  (Rin),
        .rout_vec (Rout)
    );

    assign PCout    = ctrl.pc_out;
    assign Zhighout = ctrl.zhigh_out;
    assign Zlowout  = ctrl.zlow_out;
    assign MDRout   = ctrl.mdr_out;
    assign HIout    = ctrl.hi_out;
    assign LOout    = ctrl.lo_out;
    assign Cout     = ctrl.c_out;
    assign BAout    = ctrl.ba_out;
    assign PCin     = ctrl.pc_in;
    assign MARin    = ctrl.mar_in;
    assign MDRin    = ctrl.mdr_in;
    assign IRin     = ctrl.ir_in;
    assign Yin      = ctrl.y_in;
    assign Zin      = ctrl.z_in;
    assign HIin     = ctrl.hi_in;
    assign LOin     = ctrl.lo_in;
    assign IncPC    = ctrl.inc_pc;
    assign Read     = ctrl.read;
    assign Write    = ctrl.write;

    assign alu_op   = ctrl.alu_add ? OP_ADD :
                      ctrl.alu_en  ? op     : '0;

    assign Busy     = (state != S_IDLE) && (state != S_HALT);
    assign Halted   = (state == S_HALT);
    assign Illegal  = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//   Directed bench for control_unit. Two instances: dut0 (MEM_WAIT=0) for
//   ALU / mul / nop / halt / illegal / Stop sequences, dut2 (MEM_WAIT=2)
//   for ld / st wait handling and reset abort. Each cycle the full output
//   set is packed into one word and compared at the falling edge against a
//   hand-written expectation.
// ---------------------------------------------------------------------------
module tb_control_unit;

    // Single-bit output positions in the packed strobe word
    localparam logic [21:0] M_PCOUT   = 22'h000001;
    localparam logic [21:0] M_ZHIGH   = 22'h000002;
    localparam logic [21:0] M_ZLOW    = 22'h000004;
    localparam logic [21:0] M_MDROUT  = 22'h000008;
    localparam logic [21:0] M_HIOUT   = 22'h000010;
    localparam logic [21:0] M_LOOUT   = 22'h000020;
    localparam logic [21:0] M_COUT    = 22'h000040;
    localparam logic [21:0] M_BAOUT   = 22'h000080;
    localparam logic [21:0] M_PCIN    = 22'h000100;
    localparam logic [21:0] M_MARIN   = 22'h000200;
    localparam logic [21:0] M_MDRIN   = 22'h000400;
    localparam logic [21:0] M_IRIN    = 22'h000800;
    localparam logic [21:0] M_YIN     = 22'h001000;
    localparam logic [21:0] M_ZIN     = 22'h002000;
    localparam logic [21:0] M_HIIN    = 22'h004000;
    localparam logic [21:0] M_LOIN    = 22'h008000;
    localparam logic [21:0] M_INCPC   = 22'h010000;
    localparam logic [21:0] M_READ    = 22'h020000;
    localparam logic [21:0] M_WRITE   = 22'h040000;
    localparam logic [21:0] M_BUSY    = 22'h080000;
    localparam logic [21:0] M_HALTED  = 22'h100000;
    localparam logic [21:0] M_ILLEGAL = 22'h200000;

    localparam logic [21:0] E_NONE = 22'h0;
    localparam logic [21:0] E_T0   = M_PCOUT | M_MARIN | M_INCPC | M_PCIN | M_BUSY;
    localparam logic [21:0] E_T1   = M_READ | M_MDRIN | M_BUSY;
    localparam logic [21:0] E_T2   = M_MDROUT | M_IRIN | M_BUSY;

    localparam logic [31:0] IR_AND  = 32'h28918000; // and R1,R2,R3
    localparam logic [31:0] IR_ADD  = 32'h18228000; // add R0,R4,R5
    localparam logic [31:0] IR_MUL  = 32'h79880000; // mul R3,R1
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_ILL  = 32'hF8000000;
    localparam logic [31:0] IR_LD   = 32'h01080010; // ld R2,0x10(R1)
    localparam logic [31:0] IR_ST   = 32'h11080010; // st R2,0x10(R1)

    logic        Clock;
    logic        rst0, run0, stop0;
    logic [31:0] ir0;
    logic        rst2, run2, stop2;
    logic [31:0] ir2;

    wire  [21:0] s0, s2;
    wire  [15:0] rin0, rout0, rin2, rout2;
    wire  [4:0]  alu0, alu2;
    wire  [63:0] obs0 = {5'b0, s0, rin0, rout0, alu0};
    wire  [63:0] obs2 = {5'b0, s2, rin2, rout2, alu2};

    int checks   = 0;
    int failures = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    control_unit #(.MEM_WAIT(0)) dut0 (
        .Clock(Clock), .Resetn(rst0), .Run(run0), .Stop(stop0), .IR(ir0),
        .PCout(s0[0]), .Zhighout(s0[1]), .Zlowout(s0[2]), .MDRout(s0[3]),
        .HIout(s0[4]), .LOout(s0[5]), .Cout(s0[6]), .BAout(s0[7]),
        .PCin(s0[8]), .MARin(s0[9]), .MDRin(s0[10]), .IRin(s0[11]),
        .Yin(s0[12]), .Zin(s0[13]), .HIin(s0[14]), .LOin(s0[15]),
        .IncPC(s0[16]), .Read(s0[17]), .Write(s0[18]),
        .Busy(s0[19]), .Halted(s0[20]), .Illegal(s0[21]),
        .Rin(rin0), .Rout(rout0), .alu_op(alu0)
    );

    control_unit #(.MEM_WAIT(2)) dut2 (
        .Clock(Clock), .Resetn(rst2), .Run(run2), .Stop(stop2), .IR(ir2),
        .PCout(s2[0]), .Zhighout(s2[1]), .Zlowout(s2[2]), .MDRout(s2[3]),
        .HIout(s2[4]), .LOout(s2[5]), .Cout(s2[6]), .BAout(s2[7]),
        .PCin(s2[8]), .MARin(s2[9]), .MDRin(s2[10]), .IRin(s2[11]),
        .Yin(s2[12]), .Zin(s2[13]), .HIin(s2[14]), .LOin(s2[15]),
        .IncPC(s2[16]), .Read(s2[17]), .Write(s2[18]),
        .Busy(s2[19]), .Halted(s2[20]), .Illegal(s2[21]),
        .Rin(rin2), .Rout(rout2), .alu_op(alu2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [21:0] s, input logic [15:0] rin,
                                         input logic [15:0] rout, input logic [4:0] alu);
        return {5'b0, s, rin, rout, alu};
    endfunction

    // Wait for the next falling edge and compare one instance's outputs.
    task automatic step(input int which, input string tag, input logic [21:0] s,
                        input logic [15:0] rin, input logic [15:0] rout, input logic [4:0] alu);
        @(negedge Clock);
        check(tag, (which == 0) ? obs0 : obs2, pack(s, rin, rout, alu));
    endtask

    task automatic fetch(input int which, input string tag, input int t1_cycles);
        step(which, {tag, "_t0"}, E_T0, 16'h0, 16'h0, 5'd0);
        if (which == 0) run0 = 1'b0; else run2 = 1'b0;
        for (int i = 0; i < t1_cycles; i++) step(which, {tag, "_t1"}, E_T1, 16'h0, 16'h0, 5'd0);
        step(which, {tag, "_t2"}, E_T2, 16'h0, 16'h0, 5'd0);
    endtask

    initial begin
        rst0 = 1'b0; run0 = 1'b0; stop0 = 1'b0; ir0 = 32'h0;
        rst2 = 1'b0; run2 = 1'b0; stop2 = 1'b0; ir2 = 32'h0;
        repeat (2) @(negedge Clock);
        rst0 = 1'b1;
        rst2 = 1'b1;
        check("reset_idle0", obs0, 64'h0);
        check("reset_idle2", obs2, 64'h0);

        // ---------------- dut0: and R1,R2,R3 ----------------
        run0 = 1'b1; ir0 = IR_AND;
        fetch(0, "and", 1);
        step(0, "and_t3", M_YIN | M_BUSY,  16'h0000, 16'h0004, 5'd0);
        step(0, "and_t4", M_ZIN | M_BUSY,  16'h0000, 16'h0008, 5'b00101);
        step(0, "and_t5", M_ZLOW | M_BUSY, 16'h0002, 16'h0000, 5'd0);

        // ---------------- nop: T3 is the boundary ----------------
        step(0, "nop_t0", E_T0, 16'h0, 16'h0, 5'd0);
        ir0 = IR_NOP;
        step(0, "nop_t1", E_T1, 16'h0, 16'h0, 5'd0);
        step(0, "nop_t2", E_T2, 16'h0, 16'h0, 5'd0);
        step(0, "nop_t3", M_BUSY, 16'h0, 16'h0, 5'd0);

        // ---------------- mul R3,R1; Stop held mid-instruction is ignored ----
        step(0, "mul_t0", E_T0, 16'h0, 16'h0, 5'd0);
        ir0 = IR_MUL;
        step(0, "mul_t1", E_T1, 16'h0, 16'h0, 5'd0);
        step(0, "mul_t2", E_T2, 16'h0, 16'h0, 5'd0);
        step(0, "mul_t3", M_YIN | M_BUSY, 16'h0000, 16'h0008, 5'd0);
        stop0 = 1'b1;
        step(0, "mul_t4", M_ZIN | M_BUSY, 16'h0000, 16'h0002, 5'b01111);
        step(0, "mul_t5", M_ZLOW | M_LOIN | M_BUSY, 16'h0, 16'h0, 5'd0);
        step(0, "mul_t6", M_ZHIGH | M_HIIN | M_BUSY, 16'h0, 16'h0, 5'd0);
        stop0 = 1'b0;

        // ---------------- add R0,R4,R5 with Stop at T5 ----------------
        step(0, "add_t0", E_T0, 16'h0, 16'h0, 5'd0);
        ir0 = IR_ADD;
        step(0, "add_t1", E_T1, 16'h0, 16'h0, 5'd0);
        step(0, "add_t2", E_T2, 16'h0, 16'h0, 5'd0);
        step(0, "add_t3", M_YIN | M_BUSY,  16'h0000, 16'h0010, 5'd0);
        step(0, "add_t4", M_ZIN | M_BUSY,  16'h0000, 16'h0020, 5'b00011);
        step(0, "add_t5", M_ZLOW | M_BUSY, 16'h0001, 16'h0000, 5'd0);
        stop0 = 1'b1;
        step(0, "stop_idle", E_NONE, 16'h0, 16'h0, 5'd0);
        stop0 = 1'b0;
        step(0, "idle_hold", E_NONE, 16'h0, 16'h0, 5'd0);

        // ---------------- halt: Run toggling ignored ----------------
        ir0 = IR_HALT; run0 = 1'b1;
        fetch(0, "halt", 1);
        run0 = 1'b1;
        step(0, "halt_t3", M_BUSY, 16'h0, 16'h0, 5'd0);
        step(0, "halted_a", M_HALTED, 16'h0, 16'h0, 5'd0);
        run0 = 1'b0;
        step(0, "halted_b", M_HALTED, 16'h0, 16'h0, 5'd0);
        run0 = 1'b1;
        step(0, "halted_c", M_HALTED, 16'h0, 16'h0, 5'd0);
        rst0 = 1'b0;
        #1 check("halt_reset", obs0, 64'h0);

        // ---------------- undefined opcode: Illegal sticky ----------------
        @(negedge Clock);
        rst0 = 1'b1; ir0 = IR_ILL; run0 = 1'b1;
        fetch(0, "ill", 1);
        step(0, "ill_t3", M_BUSY, 16'h0, 16'h0, 5'd0);
        step(0, "ill_halt_a", M_HALTED | M_ILLEGAL, 16'h0, 16'h0, 5'd0);
        run0 = 1'b1;
        step(0, "ill_halt_b", M_HALTED | M_ILLEGAL, 16'h0, 16'h0, 5'd0);
        rst0 = 1'b0; run0 = 1'b0;
        #1 check("ill_reset", obs0, 64'h0);
        @(negedge Clock);
        rst0 = 1'b1;
        step(0, "ill_cleared", E_NONE, 16'h0, 16'h0, 5'd0);

        // ---------------- dut2: ld R2,0x10(R1), MEM_WAIT=2 ----------------
        run2 = 1'b1; ir2 = IR_LD;
        fetch(1, "ld", 3);
        step(1, "ld_t3", M_BAOUT | M_YIN | M_BUSY, 16'h0000, 16'h0002, 5'd0);
        step(1, "ld_t4", M_COUT | M_ZIN | M_BUSY,  16'h0000, 16'h0000, 5'b00011);
        step(1, "ld_t5", M_ZLOW | M_MARIN | M_BUSY, 16'h0, 16'h0, 5'd0);
        for (int i = 0; i < 3; i++) step(1, "ld_t6", E_T1, 16'h0, 16'h0, 5'd0);
        step(1, "ld_t7", M_MDROUT | M_BUSY, 16'h0004, 16'h0000, 5'd0);
        stop2 = 1'b1;
        step(1, "ld_stop_idle", E_NONE, 16'h0, 16'h0, 5'd0);
        stop2 = 1'b0;

        // ---------------- st R2,0x10(R1), MEM_WAIT=2 ----------------
        run2 = 1'b1; ir2 = IR_ST;
        fetch(1, "st", 3);
        step(1, "st_t3", M_BAOUT | M_YIN | M_BUSY, 16'h0000, 16'h0002, 5'd0);
        step(1, "st_t4", M_COUT | M_ZIN | M_BUSY,  16'h0000, 16'h0000, 5'b00011);
        step(1, "st_t5", M_ZLOW | M_MARIN | M_BUSY, 16'h0, 16'h0, 5'd0);
        step(1, "st_t6", M_MDRIN | M_BUSY, 16'h0000, 16'h0004, 5'd0);
        for (int i = 0; i < 3; i++) step(1, "st_t7", M_WRITE | M_BUSY, 16'h0, 16'h0, 5'd0);
        stop2 = 1'b1;
        step(1, "st_stop_idle", E_NONE, 16'h0, 16'h0, 5'd0);
        stop2 = 1'b0;

        // ---------------- reset during T1 of ld aborts at once ----------------
        run2 = 1'b1; ir2 = IR_LD;
        step(1, "abort_t0", E_T0, 16'h0, 16'h0, 5'd0);
        run2 = 1'b0;
        step(1, "abort_t1", E_T1, 16'h0, 16'h0, 5'd0);
        rst2 = 1'b0;
        #1 check("abort_reset", obs2, 64'h0);
        @(negedge Clock);
        rst2 = 1'b1;
        step(1, "abort_idle", E_NONE, 16'h0, 16'h0, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
